// File: rtl/hex_display_driver_pkg.sv
// Shared constants and types for the multiplexed hex display driver:
// segment code table, blank code, control characters and byte classification.
package hex_display_driver_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is written first in the concatenation
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_HEX,
        CMD_BS,
        CMD_ESC
    } cmd_e;

    typedef struct packed {
        cmd_e       cmd;
        logic [3:0] value;
    } rx_cmd_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } entry_t;

    function automatic rx_cmd_t classify_byte(input logic [7:0] b);
        rx_cmd_t r;
        r.cmd   = CMD_NONE;
        r.value = 4'h0;
        if (b >= 8'h30 && b <= 8'h39) begin
            r.cmd   = CMD_HEX;
            r.value = 4'(b - 8'h30);
        end else if (b >= 8'h41 && b <= 8'h46) begin
            r.cmd   = CMD_HEX;
            r.value = 4'(b - 8'h37);
        end else if (b >= 8'h61 && b <= 8'h66) begin
            r.cmd   = CMD_HEX;
            r.value = 4'(b - 8'h57);
        end else if (b == ASCII_BS) begin
            r.cmd = CMD_BS;
        end else if (b == ASCII_ESC) begin
            r.cmd = CMD_ESC;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_display_driver_hex_to_seg.sv
// Combinational nibble-to-segment decoder; invalid entries are blanked.
module hex_to_seg
    import hex_display_driver_pkg::*;
(
    input  logic [3:0] value,
    input  logic       valid,
    output logic [6:0] segments
);

    assign segments = valid ? SEG_TABLE[value] : SEG_BLANK;

endmodule

// File: rtl/hex_display_driver.sv
// Four-digit multiplexed hex display fed by a UART byte stream; newest
// character on the rightmost digit, with backspace and clear support.
module hex_display_driver
    import hex_display_driver_pkg::*;
#(
    parameter int REFRESH_CLKS  = 1000,
    parameter int REFRESH_WIDTH = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       data_ready,
    output logic [6:0] segments,
    output logic [3:0] digit_sel
);

    entry_t [NUM_DIGITS-1:0] entry_reg;
    entry_t [NUM_DIGITS-1:0] entry_next;
    entry_t [NUM_DIGITS-1:0] shift_in;
    entry_t [NUM_DIGITS-1:0] shift_out;

    logic [REFRESH_WIDTH-1:0] refresh_reg;
    logic [1:0]               index_reg;
    logic                     refresh_wrap;

    logic [6:0] segments_reg;
    logic [3:0] digit_sel_reg;
    logic [6:0] seg_decoded;
    logic [3:0] sel_next;
    entry_t     selected;
    rx_cmd_t    rx_cmd;

    assign rx_cmd = classify_byte(data);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_entry
            if (gi == 0) begin : g_head
                assign shift_in[gi] = {1'b1, rx_cmd.value};
            end else begin : g_body
                assign shift_in[gi] = entry_reg[gi-1];
            end

            if (gi == NUM_DIGITS - 1) begin : g_tail
                assign shift_out[gi] = '0;
            end else begin : g_inner
                assign shift_out[gi] = entry_reg[gi+1];
            end

            assign entry_next[gi] = !data_ready              ? entry_reg[gi] :
                                    (rx_cmd.cmd == CMD_HEX)  ? shift_in[gi]  :
                                    (rx_cmd.cmd == CMD_BS)   ? shift_out[gi] :
                                    (rx_cmd.cmd == CMD_ESC)  ? entry_t'('0)  :
                                                               entry_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_reg <= '0;
        end else begin
            entry_reg <= entry_next;
        end
    end

    // Scan timing runs independently of byte traffic so a wrap never loses an update
    assign refresh_wrap = (refresh_reg == REFRESH_WIDTH'(REFRESH_CLKS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh_reg <= '0;
            index_reg   <= 2'd0;
        end else if (refresh_wrap) begin
            refresh_reg <= '0;
            index_reg   <= index_reg + 2'd1;
        end else begin
            refresh_reg <= refresh_reg + REFRESH_WIDTH'(1);
        end
    end

    assign selected = entry_reg[index_reg];
    assign sel_next = ~(4'b0001 << index_reg);

    hex_to_seg u_hex_to_seg (
        .value    (selected.value),
        .valid    (selected.valid),
        .segments (seg_decoded)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            segments_reg  <= SEG_BLANK;
            digit_sel_reg <= 4'hF;
        end else begin
            segments_reg  <= seg_decoded;
            digit_sel_reg <= sel_next;
        end
    end

    assign segments  = segments_reg;
    assign digit_sel = digit_sel_reg;

endmodule

// File: doc/hex_display_driver.md
HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_CLKS, default 1000: clocks each digit stays selected.
REQ-002 SHALL have parameter REFRESH_WIDTH, default 10: counter width; 2^REFRESH_WIDTH >= REFRESH_CLKS.
REQ-003 SHALL have port clock  input  1  single system clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data  input  8  received byte from UART receiver, valid when data_ready high.
REQ-006 SHALL have port data_ready  input  1  one-cycle strobe, accept data this cycle.
REQ-007 SHALL have port segments  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 SHALL have port digit_sel  output  4  one-hot active-low digit enable, bit0 = rightmost, registered.

Function
REQ-009 SHALL hold a 4-entry buffer; each entry = 4-bit value + valid bit; entry 0 = rightmost/newest.
REQ-010 SHALL sample data only in cycles with data_ready=1; buffer update at that clock edge.
REQ-011 SHALL map ASCII 0x30-0x39 to 0-9, 0x41-0x46 and 0x61-0x66 to 10-15; on a hex char shift entries left (3 dropped), entry 0 = value, valid=1.
REQ-012 SHALL on 0x08 (backspace) shift entries right; entry 3 becomes invalid; entry 0 dropped.
REQ-013 SHALL on 0x1B (ESC) invalidate all four entries in one cycle.
REQ-014 SHALL ignore every other byte value; buffer unchanged.
REQ-015 SHALL run refresh counter 0..REFRESH_CLKS-1, wrapping to 0; digit index 0->1->2->3->0 advances on each wrap.
REQ-016 SHALL register outputs each cycle: digit_sel = ~(1<<index), segments = decode(buffer[index]) of current register contents.
REQ-017 SHALL drive segments=7'h7F (all off) for invalid entries.
REQ-018 SHALL decode 0-F as active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-019 SHALL show accepted byte on segments at edge N+1 when byte accepted at edge N and its entry is selected (1-cycle latency).
REQ-020 SHALL apply buffer update and index advance independently when data_ready coincides with counter wrap; neither lost.
REQ-021 SHALL accept back-to-back data_ready strobes, one byte per cycle, no back-pressure.

Reset
REQ-022 SHALL on reset assert asynchronously set: all entries invalid, value 0, counter 0, index 0, segments=7'h7F, digit_sel=4'hF.
REQ-023 SHALL drive digit_sel=4'hE at first rising edge after reset release.
REQ-024 SHALL on reset mid-scan or mid-byte discard all state; no partial update survives.

Structure
REQ-025 SHALL place in shared package: segment code table 0-F, SEG_BLANK=7'h7F, ASCII constants BS=0x08, ESC=0x1B.
REQ-026 SHALL implement decode as combinational sub-module hex_to_seg (4-bit value + valid in, 7-bit segments out).

Verification (bench REFRESH_CLKS=4)
REQ-027 SHALL cover: reset -> segments=7F, digit_sel=F; one edge after release digit_sel=E, segments=7F.
REQ-028 SHALL cover: bytes '1','2','A','f' -> scanning digits 0..3 gives 0E,08,24,79.
REQ-029 SHALL cover: after "12AF", 0x08 -> digits 0..3 = 08,24,79,7F; then 0x1B -> all digits 7F.
REQ-030 SHALL cover: bytes 0x47 'G', 0x20, 0xFF -> buffer and segments unchanged.
REQ-031 SHALL cover: '5' with data_ready on counter-wrap cycle while index=3 -> index 0 next, segments=12 one cycle later.
REQ-032 SHALL cover: reset pulse while "1234" displayed mid-refresh -> outputs 7F/F immediately, no digit shown after release.
